// File: rtl/array_fill_stream_pkg.sv
// Shared types and default sizing for the array fill/stream block.
package array_fill_pkg;

   localparam int DSIZE_DEF = 32;
   localparam int DEPTH_DEF = 32;

   // Fill pattern selected by cmd_mode; RSVD behaves like CLEAR.
   typedef enum logic [1:0] {
      CLEAR = 2'b00,
      SET   = 2'b01,
      INDEX = 2'b10,
      RSVD  = 2'b11
   } fill_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FILL  = 2'b01,
      DRAIN = 2'b10
   } state_e;

endpackage

// File: rtl/array_fill_stream_if.sv
// Command / row-stream bundle for array_fill_stream.
// Optional out_parity present when ARRAY_FILL_STREAM_PARITY_EN is defined.
interface array_fill_stream_if
   import array_fill_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF,
   parameter int DEPTH = DEPTH_DEF
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [1:0]               cmd_mode;
   logic                     out_valid;
   logic                     out_ready;
   logic [DSIZE-1:0]         out_data;
   logic [$clog2(DEPTH)-1:0] out_index;
   logic                     out_last;
   logic                     busy;
`ifdef ARRAY_FILL_STREAM_PARITY_EN
   logic                     out_parity;
`endif

   // Block side
   modport slave (
      input  cmd_valid, cmd_mode, out_ready,
      output cmd_ready, out_valid, out_data, out_index, out_last, busy
`ifdef ARRAY_FILL_STREAM_PARITY_EN
      , output out_parity
`endif
   );

   // Requester / consumer side
   modport master (
      output cmd_valid, cmd_mode, out_ready,
      input  cmd_ready, out_valid, out_data, out_index, out_last, busy
`ifdef ARRAY_FILL_STREAM_PARITY_EN
      , input out_parity
`endif
   );

endinterface

// File: rtl/array_fill_stream.sv
// array_fill_stream: fills a DEPTH x DSIZE register array with a pattern
// (clear / set / row index), then streams the rows out over a valid/ready
// handshake. Optional macro ARRAY_FILL_STREAM_PARITY_EN adds out_parity,
// the registered XOR of out_data.
module array_fill_stream
   import array_fill_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                clock,
   input  logic                rst,
   array_fill_stream_if.slave  bus
);

   localparam int             IW       = $clog2(DEPTH);
   localparam logic [IW-1:0]  LAST_IDX = IW'(DEPTH - 1);

   state_e           state_q, state_d;
   fill_mode_e       mode_q, mode_d;
   logic [IW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    cnt_inc;
   logic [DSIZE-1:0] dout_q, dout_d;
   logic             last_q, last_d;
   logic [DSIZE-1:0] row_val;
   logic             wr_en;
   logic [DSIZE-1:0] arr_q [DEPTH-1:0];
`ifdef ARRAY_FILL_STREAM_PARITY_EN
   logic             par_q, par_d;
`endif

   // Power-of-two DEPTH makes this wrap cleanly at DEPTH.
   assign cnt_inc = cnt_q + IW'(1);

   // Pattern for the row being written this FILL cycle.
   always_comb begin
      case (mode_q)
         SET:     row_val = '1;
         INDEX:   row_val = DSIZE'(cnt_q);
         default: row_val = '0;
      endcase
   end

   // Next-state and datapath control; output rows are preloaded into
   // dout_q so out_data is always a register.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      last_d  = last_q;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            dout_d = '0;
            last_d = 1'b0;
            if (bus.cmd_valid) begin
               mode_d  = fill_mode_e'(bus.cmd_mode);
               state_d = FILL;
            end
         end
         FILL: begin
            wr_en = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_q == LAST_IDX) begin
               // Row 0 was written DEPTH-1 cycles ago, safe to present now.
               state_d = DRAIN;
               cnt_d   = '0;
               dout_d  = arr_q[0];
               last_d  = 1'b0;
            end
         end
         DRAIN: begin
            if (bus.out_ready) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  dout_d  = '0;
                  last_d  = 1'b0;
               end else begin
                  cnt_d  = cnt_inc;
                  dout_d = arr_q[cnt_inc];
                  last_d = (cnt_inc == LAST_IDX);
               end
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef ARRAY_FILL_STREAM_PARITY_EN
      par_d = ^dout_d;
`endif
   end

   // FSM and output registers.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= CLEAR;
         cnt_q   <= '0;
         dout_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         last_q  <= last_d;
      end
   end

`ifdef ARRAY_FILL_STREAM_PARITY_EN
   // Parity travels with dout_q so it stays aligned with out_data.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end
   assign bus.out_parity = par_q;
`endif

   // Row storage; reset wipes every row.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) arr_q[r] <= '0;
      end else if (wr_en) begin
         arr_q[cnt_q] <= row_val;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.out_valid = (state_q == DRAIN);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_data  = dout_q;
   assign bus.out_index = cnt_q;
   assign bus.out_last  = last_q;

endmodule
